// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: beat-latched glyph buffer plus double-dabble numeric buffer.
// Build macro SEG_SCAN_LZ_BLANK_EN blanks numeric leading zeros (least significant digit always shown).
module seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int GLYPH_BITS = 5,
  parameter int VALUE_BITS = 14,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             mode,
  input  logic                             beat,
  input  logic [NUM_DIGITS*GLYPH_BITS-1:0] glyphs,
  input  logic [VALUE_BITS-1:0]            value,
  input  logic                             value_load,
  output logic                             busy,
  output logic [6:0]                       seg,
  output logic [NUM_DIGITS-1:0]            an
);

  localparam int DIV_W   = $clog2(SCAN_DIV);
  localparam int DIG_W   = $clog2(NUM_DIGITS);
  localparam int CNT_W   = $clog2(VALUE_BITS);
  localparam int BCD_RAW = (VALUE_BITS * 30103) / 100000 + 1;
  localparam int BCD_N   = (BCD_RAW > NUM_DIGITS) ? BCD_RAW : NUM_DIGITS;
  localparam int BCD_W   = 4 * BCD_N;
  localparam int NUM_W   = 4 * NUM_DIGITS;

`ifdef SEG_SCAN_LZ_BLANK_EN
  localparam logic LZ_BLANK = 1'b1;
`else
  localparam logic LZ_BLANK = 1'b0;
`endif

  localparam logic [6:0] SEG_BLANK            = 7'h7F;
  localparam logic [6:0] SEG_ARROW_UP         = 7'h7E;
  localparam logic [6:0] SEG_ARROW_DOWN       = 7'h77;
  localparam logic [6:0] SEG_ARROW_LEFT       = 7'h4F;
  localparam logic [6:0] SEG_ARROW_RIGHT      = 7'h79;
  localparam logic [6:0] SEG_ARROW_UP_DOWN    = 7'h76;
  localparam logic [6:0] SEG_ARROW_UP_LEFT    = 7'h5E;
  localparam logic [6:0] SEG_ARROW_UP_RIGHT   = 7'h7C;
  localparam logic [6:0] SEG_ARROW_DOWN_LEFT  = 7'h67;
  localparam logic [6:0] SEG_ARROW_DOWN_RIGHT = 7'h73;
  localparam logic [6:0] SEG_ARROW_LEFT_RIGHT = 7'h49;
  localparam logic [6:0] SEG_ARROW_NONE       = 7'h3F;

  localparam logic [GLYPH_BITS-1:0]            GLYPH_NONE = GLYPH_BITS'(20);
  localparam logic [NUM_DIGITS*GLYPH_BITS-1:0] GLYPH_RST  = {NUM_DIGITS{GLYPH_NONE}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  function automatic logic [6:0] seg_decode(input logic [31:0] code);
    case (code)
      32'd0:   seg_decode = 7'h40;
      32'd1:   seg_decode = 7'h79;
      32'd2:   seg_decode = 7'h24;
      32'd3:   seg_decode = 7'h30;
      32'd4:   seg_decode = 7'h19;
      32'd5:   seg_decode = 7'h12;
      32'd6:   seg_decode = 7'h02;
      32'd7:   seg_decode = 7'h78;
      32'd8:   seg_decode = 7'h00;
      32'd9:   seg_decode = 7'h10;
      32'd10:  seg_decode = SEG_ARROW_UP;
      32'd11:  seg_decode = SEG_ARROW_DOWN;
      32'd12:  seg_decode = SEG_ARROW_LEFT;
      32'd13:  seg_decode = SEG_ARROW_RIGHT;
      32'd14:  seg_decode = SEG_ARROW_UP_DOWN;
      32'd15:  seg_decode = SEG_ARROW_UP_LEFT;
      32'd16:  seg_decode = SEG_ARROW_UP_RIGHT;
      32'd17:  seg_decode = SEG_ARROW_DOWN_LEFT;
      32'd18:  seg_decode = SEG_ARROW_DOWN_RIGHT;
      32'd19:  seg_decode = SEG_ARROW_LEFT_RIGHT;
      32'd20:  seg_decode = SEG_ARROW_NONE;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  logic                             beat_meta_q, beat_sync_q, beat_prev_q;
  logic                             beat_rise_s;
  logic [NUM_DIGITS*GLYPH_BITS-1:0] glyph_q;

  conv_state_e                      state_q;
  logic                             busy_q;
  logic [CNT_W-1:0]                 cnt_q;
  logic [VALUE_BITS-1:0]            bin_q;
  logic [BCD_W-1:0]                 bcd_q, bcd_adj_s;
  logic                             pend_valid_q;
  logic [VALUE_BITS-1:0]            pend_val_q;
  logic [NUM_W-1:0]                 num_q, num_d;
  logic                             overflow_s;

  logic [DIV_W-1:0]                 div_q;
  logic [DIG_W-1:0]                 dig_q;
  logic                             terminal_s;
  logic [GLYPH_BITS-1:0]            glyph_code_s;
  logic [3:0]                       num_digit_s;
  logic                             lead_zero_s, blank_s;
  logic [6:0]                       seg_q, seg_d;
  logic [NUM_DIGITS-1:0]            an_q, an_d;

  assign beat_rise_s = beat_sync_q & ~beat_prev_q;
  assign terminal_s  = (div_q == DIV_W'(SCAN_DIV - 1));
  assign busy        = busy_q;
  assign seg         = seg_q;
  assign an          = an_q;

  // Beat synchroniser, edge history and glyph buffer load one cycle after edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_meta_q <= 1'b0;
      beat_sync_q <= 1'b0;
      beat_prev_q <= 1'b0;
      glyph_q     <= GLYPH_RST;
    end else begin
      beat_meta_q <= beat;
      beat_sync_q <= beat_meta_q;
      beat_prev_q <= beat_sync_q;
      if (beat_rise_s) begin
        glyph_q <= glyphs;
      end else begin
        glyph_q <= glyph_q;
      end
    end
  end

  // Add-3 correction per BCD digit, overflow detection and MSD-first commit image
  always_comb begin
    bcd_adj_s  = bcd_q;
    overflow_s = 1'b0;
    num_d      = '0;
    for (int j = 0; j < BCD_N; j++) begin
      bcd_adj_s[j*4 +: 4] = (bcd_q[j*4 +: 4] >= 4'd5) ? (bcd_q[j*4 +: 4] + 4'd3) : bcd_q[j*4 +: 4];
    end
    for (int j = NUM_DIGITS; j < BCD_N; j++) begin
      overflow_s = overflow_s | (bcd_q[j*4 +: 4] != 4'd0);
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      num_d[k*4 +: 4] = overflow_s ? 4'd9 : bcd_q[(NUM_DIGITS-1-k)*4 +: 4];
    end
  end

  // Converter FSM: IDLE -> SHIFT (VALUE_BITS cycles) -> COMMIT, with one latest-wins pending slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_val_q   <= '0;
      num_q        <= '0;
    end else begin
      if (value_load && (state_q != ST_IDLE)) begin
        pend_valid_q <= 1'b1;
        pend_val_q   <= value;
      end else begin
        pend_val_q   <= pend_val_q;
      end
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          bcd_q <= '0;
          if (value_load) begin
            bin_q        <= value;
            pend_valid_q <= 1'b0;
            state_q      <= ST_SHIFT;
            busy_q       <= 1'b1;
          end else if (pend_valid_q) begin
            bin_q        <= pend_val_q;
            pend_valid_q <= 1'b0;
            state_q      <= ST_SHIFT;
            busy_q       <= 1'b1;
          end else begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
          end
        end
        ST_SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj_s, bin_q} << 1;
          cnt_q          <= cnt_q + CNT_W'(1);
          busy_q         <= 1'b1;
          if (cnt_q == CNT_W'(VALUE_BITS - 1)) begin
            state_q <= ST_COMMIT;
          end else begin
            state_q <= ST_SHIFT;
          end
        end
        ST_COMMIT: begin
          num_q   <= num_d;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Select the current digit's source, blanking and anode pattern
  always_comb begin
    glyph_code_s = '0;
    num_digit_s  = 4'd0;
    lead_zero_s  = 1'b1;
    blank_s      = 1'b0;
    an_d         = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      lead_zero_s = lead_zero_s & (num_q[k*4 +: 4] == 4'd0);
      if (dig_q == DIG_W'(k)) begin
        glyph_code_s           = glyph_q[k*GLYPH_BITS +: GLYPH_BITS];
        num_digit_s            = num_q[k*4 +: 4];
        blank_s                = lead_zero_s & (k != NUM_DIGITS - 1);
        an_d[NUM_DIGITS-1-k]   = 1'b0;
      end else begin
        an_d[NUM_DIGITS-1-k]   = 1'b1;
      end
    end
    if (mode) begin
      seg_d = (LZ_BLANK && blank_s) ? SEG_BLANK : seg_decode(32'(num_digit_s));
    end else begin
      seg_d = seg_decode(32'(glyph_code_s));
    end
  end

  // Dwell divider, digit index and registered segment/anode drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      dig_q <= '0;
      seg_q <= SEG_BLANK;
      an_q  <= '1;
    end else if (terminal_s) begin
      div_q <= '0;
      dig_q <= (dig_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : (dig_q + DIG_W'(1));
      seg_q <= seg_d;
      an_q  <= an_d;
    end else begin
      div_q <= div_q + DIV_W'(1);
      dig_q <= dig_q;
      seg_q <= seg_q;
      an_q  <= an_q;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: randomized glyph/numeric stimulus against an arithmetic display model.
module tb_seg_scan_driver;
  localparam int N  = 4;
  localparam int GB = 5;
  localparam int VB = 14;
  localparam int SD = 4;

  // Active-low patterns: codes 0-9 digits, 10-20 arrows UP..NONE
  localparam logic [6:0] TAB [0:20] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                                        7'h78, 7'h00, 7'h10, 7'h7E, 7'h77, 7'h4F, 7'h79,
                                        7'h76, 7'h5E, 7'h7C, 7'h67, 7'h73, 7'h49, 7'h3F};

  logic            clk = 1'b0;
  logic            rst_n, mode, beat, value_load, busy;
  logic [N*GB-1:0] glyphs;
  logic [VB-1:0]   value;
  logic [6:0]      seg;
  logic [N-1:0]    an;

  int         total = 0;
  int         bad   = 0;
  int         glyph_model [N];
  int         num_model;
  logic [6:0] fr_seg [N];

  seg_scan_driver #(.NUM_DIGITS(N), .GLYPH_BITS(GB), .VALUE_BITS(VB), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .beat(beat), .glyphs(glyphs),
    .value(value), .value_load(value_load), .busy(busy), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_glyph(int code);
    return (code <= 20) ? TAB[code] : 7'h7F;
  endfunction

  function automatic logic [6:0] exp_num(int v, int k);
    int p;
    p = 1;
    for (int i = 0; i < N - 1 - k; i++) p = p * 10;
    if (v >= 10000) return TAB[9];
`ifdef SEG_SCAN_LZ_BLANK_EN
    if (k < N - 1 && v / p == 0) return 7'h7F;
`endif
    return TAB[(v / p) % 10];
  endfunction

  function automatic logic [N-1:0] an_for(int d);
    return 4'hF ^ (4'b1000 >> d);
  endfunction

  task automatic capture_frame(input string tag);
    logic [N-1:0] prev;
    int guard;
    guard = 0;
    prev  = an;
    @(negedge clk);
    while (!(an == 4'b0111 && prev != 4'b0111) && guard < 8*N*SD) begin
      prev = an;
      @(negedge clk);
      guard++;
    end
    total++;
    if (guard >= 8*N*SD) begin
      bad++;
      $display("FAIL %s frame_sync: an=%b never entered digit 0 within %0d cycles", tag, an, guard);
    end
    for (int d = 0; d < N; d++) begin
      fr_seg[d] = seg;
      total++;
      if (an !== an_for(d)) begin
        bad++;
        $display("FAIL %s an_digit%0d: got %b want %b", tag, d, an, an_for(d));
      end
      if (d < N - 1) repeat (SD) @(negedge clk);
    end
  endtask

  task automatic check_glyph_frame(input string tag);
    capture_frame(tag);
    for (int d = 0; d < N; d++) begin
      total++;
      if (fr_seg[d] !== exp_glyph(glyph_model[d])) begin
        bad++;
        $display("FAIL %s glyph_digit%0d: got %h want %h (code %0d)", tag, d, fr_seg[d], exp_glyph(glyph_model[d]), glyph_model[d]);
      end
    end
  endtask

  task automatic check_num_frame(input string tag);
    capture_frame(tag);
    for (int d = 0; d < N; d++) begin
      total++;
      if (fr_seg[d] !== exp_num(num_model, d)) begin
        bad++;
        $display("FAIL %s num_digit%0d: got %h want %h (value %0d)", tag, d, fr_seg[d], exp_num(num_model, d), num_model);
      end
    end
  endtask

  task automatic pulse_beat();
    @(negedge clk);
    #($urandom_range(1, 4));
    beat = 1'b1;
    repeat (6) @(negedge clk);
    beat = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic convert(input int v, output int busy_len);
    @(negedge clk);
    value      = VB'(v);
    value_load = 1'b1;
    @(negedge clk);
    value_load = 1'b0;
    busy_len   = 0;
    while (busy === 1'b1 && busy_len < 100) begin
      busy_len++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; beat = 1'b0; value_load = 1'b0; value = '0; glyphs = '0;
    for (int k = 0; k < N; k++) glyph_model[k] = 20;
    num_model = 0;
    repeat (3) @(negedge clk);
    total += 3;
    if (an !== 4'hF)     begin bad++; $display("FAIL reset_an: got %b want 1111", an); end
    if (seg !== 7'h7F)   begin bad++; $display("FAIL reset_seg: got %h want 7f", seg); end
    if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      logic [N-1:0] want_an;
      logic [6:0]   want_seg;
      @(negedge clk);
      want_an  = (k < 4) ? 4'hF : an_for(((k - 4) / 4) % 4);
      want_seg = (k < 4) ? 7'h7F : TAB[20];
      total += 2;
      if (an !== want_an)   begin bad++; $display("FAIL scan_an_t%0d: got %b want %b", k, an, want_an); end
      if (seg !== want_seg) begin bad++; $display("FAIL scan_seg_t%0d: got %h want %h", k, seg, want_seg); end
    end
  endtask

  task automatic test_glyph();
    int fixed_codes [N] = '{10, 11, 13, 20};
    int pend [N];
    mode = 1'b0;
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < N; k++) begin
        pend[k] = (it == 0) ? fixed_codes[k] : int'($urandom_range(0, 31));
        glyphs[k*GB +: GB] = GB'(pend[k]);
      end
      pulse_beat();
      glyph_model = pend;
      check_glyph_frame("glyph");
    end
    for (int k = 0; k < N; k++) glyphs[k*GB +: GB] = GB'((glyph_model[k] + 1 + k) % 32);
    repeat (3*N*SD) @(negedge clk);
    check_glyph_frame("glyph_nobeat");
  endtask

  task automatic test_numeric();
    int vals [6] = '{1234, 16383, 7, 0, 9999, 10000};
    int blen;
    mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      int v;
      v = (i < 6) ? vals[i] : int'($urandom_range(0, 16383));
      convert(v, blen);
      total++;
      if (blen != VB + 1) begin bad++; $display("FAIL busy_len v=%0d: got %0d want %0d", v, blen, VB + 1); end
      num_model = v;
      check_num_frame("numeric");
    end
  endtask

  task automatic test_mode_switch();
    mode = 1'b0;
    check_glyph_frame("mode_to_glyph");
    mode = 1'b1;
    check_num_frame("mode_to_num");
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] prev_an;
    int guard, hits, d;
    mode = 1'b1;
    @(negedge clk); value = VB'(42); value_load = 1'b1;
    @(negedge clk); value_load = 1'b0;
    repeat (3) @(negedge clk);
    value = VB'(55); value_load = 1'b1;
    @(negedge clk); value_load = 1'b0;
    repeat (2) @(negedge clk);
    value = VB'(99); value_load = 1'b1;
    @(negedge clk); value_load = 1'b0;
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    prev_an = an;
    hits    = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) begin
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL pending_restart: busy got %b want 1", busy); end
      end
      if (an !== prev_an) begin
        d = -1;
        for (int dd = 0; dd < N; dd++) if (an === an_for(dd)) d = dd;
        total++;
        if (d < 0 || seg !== exp_num(42, d)) begin
          bad++;
          $display("FAIL first_commit_42: an=%b seg got %h", an, seg);
        end
        hits++;
      end
      prev_an = an;
    end
    total++;
    if (hits != N) begin bad++; $display("FAIL first_commit_dwells: got %0d want %0d", hits, N); end
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    num_model = 99;
    check_num_frame("pending_99");
  endtask

  task automatic test_beat_commit();
    int pend [N];
    int v, guard;
    v = int'($urandom_range(100, 9999));
    for (int k = 0; k < N; k++) begin
      pend[k] = int'($urandom_range(0, 20));
      glyphs[k*GB +: GB] = GB'(pend[k]);
    end
    mode = 1'b1;
    @(negedge clk); value = VB'(v); value_load = 1'b1;
    @(negedge clk); value_load = 1'b0;
    repeat (12) @(negedge clk);
    beat = 1'b1;
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    repeat (6) @(negedge clk);
    beat = 1'b0;
    repeat (4) @(negedge clk);
    glyph_model = pend;
    num_model   = v;
    check_num_frame("beat_commit_num");
    mode = 1'b0;
    check_glyph_frame("beat_commit_glyph");
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    mode = 1'b1;
    @(negedge clk); value = VB'(5678); value_load = 1'b1;
    @(negedge clk); value_load = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total += 3;
    if (busy !== 1'b0) begin bad++; $display("FAIL midshift_busy: got %b want 0", busy); end
    if (an !== 4'hF)   begin bad++; $display("FAIL midshift_an: got %b want 1111", an); end
    if (seg !== 7'h7F) begin bad++; $display("FAIL midshift_seg: got %h want 7f", seg); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) glyph_model[k] = 20;
    num_model = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL midshift_no_commit: busy high %0d cycles want 0", seen); end
    check_num_frame("midshift_num");
    mode = 1'b0;
    check_glyph_frame("midshift_glyph");
  endtask

  initial begin
    test_reset();
    test_glyph();
    test_numeric();
    test_mode_switch();
    test_back_to_back();
    test_beat_commit();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter GLYPH_BITS, default 5, width of one glyph code.
REQ-003 SHALL have parameter VALUE_BITS, default 14, width of the binary value to display.
REQ-004 SHALL have parameter SCAN_DIV, default 50000, clk cycles per digit dwell (>=2).
REQ-005 SHALL have port clk, input, 1, sole clock; all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port mode, input, 1, display source: 0 = glyph, 1 = numeric.
REQ-008 SHALL have port beat, input, 1, asynchronous metronome; its rising edge latches glyphs.
REQ-009 SHALL have port glyphs, input, NUM_DIGITS*GLYPH_BITS, slot k = bits [k*GLYPH_BITS +: GLYPH_BITS].
REQ-010 SHALL have port value, input, VALUE_BITS, unsigned binary for numeric mode.
REQ-011 SHALL have port value_load, input, 1, one-cycle strobe requesting conversion of value.
REQ-012 SHALL have port busy, output, 1, high while a BCD conversion runs.
REQ-013 SHALL have port seg, output, 7, active-low segments, bit0 = a ... bit6 = g.
REQ-014 SHALL have port an, output, NUM_DIGITS, active-low anodes; digit index k drives an[NUM_DIGITS-1-k].

Function
REQ-015 beat SHALL pass a 2-flop synchroniser; a rising edge SHALL be detected on the synchronised signal, and the glyph buffer SHALL load all slots in the cycle after detection.
REQ-016 Glyph codes: 0-9 decimal digits; 10-20 arrow glyphs per the shared SEG_ARROW_* constants (UP, DOWN, LEFT, RIGHT, UP_DOWN, UP_LEFT, UP_RIGHT, DOWN_LEFT, DOWN_RIGHT, LEFT_RIGHT, NONE); codes >=21 SHALL yield seg = 7'h7F.
REQ-017 Converter FSM states: IDLE, SHIFT, COMMIT. IDLE->SHIFT on value_load (value captured); SHIFT runs exactly VALUE_BITS cycles of shift-add-3 double-dabble; SHIFT->COMMIT->IDLE; busy high in SHIFT and COMMIT.
REQ-018 In COMMIT the BCD result SHALL be copied atomically into the numeric buffer; partial results SHALL never be displayed.
REQ-019 value >= 10^NUM_DIGITS SHALL display all nines.
REQ-020 value_load while busy SHALL capture value into a single pending slot (latest wins) and start a new conversion on the cycle after COMMIT.
REQ-021 Numeric digit index 0 SHALL be the most significant digit.
REQ-022 Scan divider SHALL count 0..SCAN_DIV-1; at terminal count the digit index SHALL advance, wrapping NUM_DIGITS-1 -> 0.
REQ-023 seg and an SHALL be registered and update one cycle after terminal count; exactly one an bit low at a time after the first advance.
REQ-024 mode SHALL be sampled at each digit advance; a change SHALL take effect no later than the next digit dwell; neither buffer SHALL be altered by a mode change.
REQ-025 beat edge and COMMIT in the same cycle SHALL both complete.

Reset
REQ-026 On rst_n low: an = all ones, seg = 7'h7F, busy = 0, FSM = IDLE, pending cleared, divider and digit index = 0, glyph buffer = code 20 in every slot, numeric buffer = 0, synchroniser = 0.
REQ-027 Reset during SHIFT SHALL abort the conversion; no commit SHALL follow release.

Configuration
REQ-028 Macro SEG_SCAN_LZ_BLANK_EN: when defined, numeric-mode leading zeros SHALL show seg = 7'h7F, except the least significant digit always shows; when undefined all digits SHALL show including zeros; glyph mode unaffected either way.

Verification
REQ-029 Reset, SCAN_DIV=4: an cycles 0111,1011,1101,1110,0111 with each dwell 4 clocks; seg = 7'h7F during reset.
REQ-030 mode=0, glyphs={20,13,11,10} (slot3..slot0), beat rising -> after 3-cycle latency digit 0 shows SEG_ARROW_UP, digit 3 SEG_ARROW_NONE; glyph change without beat -> no change.
REQ-031 mode=1, value=1234, value_load -> busy high 15 cycles (VALUE_BITS+1), then digits 1,2,3,4.
REQ-032 value=16383 -> 9,9,9,9; value=7 with SEG_SCAN_LZ_BLANK_EN -> blank,blank,blank,7; without -> 0,0,0,7.
REQ-033 value_load 42 then 99 during busy -> 42 committed, then 99 committed; rst_n low mid-SHIFT -> buffer 0, busy 0.
